instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer entry count, which is a power of two between 2 and 16.
REQ-002 The block SHALL have these ports, in this order (name, direction, width, meaning):
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-low.
- req_valid_i  input  1  encode request present.
- req_ready_o  output  1  block can accept a request.
- type_i  input  2  instruction class: 00 I-ALU (0010011), 01 load (0000011), 10 store S (0100011), 11 branch SB (1100011).
- funct3_i  input  3  placed in instr[14:12].
- rd_i, rs1_i, rs2_i  input  5 each  register fields.
- imm_i  input  32  signed immediate, in the same value format the decoder produces.
- out_valid_o  output  1  head instruction valid.
- out_ready_i  input  1  consumer takes the head entry.
- instr_o  output  32  encoded head instruction.
- addr_o  output  32  byte address assigned to the head instruction.
- count_o  output  5  buffer occupancy.
- err_o  output  1  one-cycle pulse on a rejected request.
- err_cnt_o  output  8  rejected-request count, saturating at 255.

Function
REQ-003 Field placement SHALL be: opcode from type_i in [6:0]; funct3_i in [14:12]; rs1_i in [19:15]; rd_i in [11:7] for I/load; rs2_i in [24:20] for S/SB.
REQ-004 For I-ALU with funct3 000, and for load, the encoding SHALL be [31:20]=imm_i[11:0].
REQ-005 For I-ALU with funct3 101, the encoding SHALL be [31:25]=0100000 and [24:20]=imm_i[4:0].
REQ-006 For S, the encoding SHALL be [31:25]=imm_i[11:5] and [11:7]=imm_i[4:0].
REQ-007 For SB, the encoding SHALL be [31]=imm_i[11], [7]=imm_i[10], [30:25]=imm_i[9:4] and [11:8]=imm_i[3:0].
- Round trip: decoding the output immediate SHALL return imm_i.
REQ-008 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both high.
- An accepted, non-rejected request is encoded and pushed in that same edge.
- out_valid_o for that entry SHALL rise on the next cycle (1-cycle latency).
REQ-009 req_ready_o SHALL equal (count_o < FIFO_DEPTH); it SHALL NOT depend on out_ready_i.
REQ-010 A pop SHALL occur when out_valid_o and out_ready_i are both high; out_valid_o SHALL equal (count_o != 0).
REQ-011 Push and pop in the same cycle SHALL leave count_o unchanged; entries SHALL leave in FIFO order and the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-012 Address counter:
- The counter starts at 0 and is stored with each pushed entry.
- It advances by 4 per push, wrapping at 2^32.
- A rejected request SHALL NOT advance it.
REQ-013 instr_o and addr_o SHALL hold the head entry while out_valid_o is high and SHALL be 0 when the buffer is empty.

Reset
REQ-014 With rst_i low at a rising edge, all outputs and state SHALL take these values, even with requests in flight, and buffered entries SHALL be discarded:
- count_o=0, out_valid_o=0, instr_o=0, addr_o=0.
- err_o=0, err_cnt_o=0, address counter=0.
- req_ready_o=1 on the first cycle after reset is released.

Configuration
REQ-015 Macro ENC_RANGE_CHECK_EN SHALL select range checking.
- Defined: a request SHALL be rejected when any of these holds:
  - I/load/S/SB with imm_i outside -2048..2047;
  - funct3 101 with imm_i outside 0..31;
  - I-ALU with funct3 other than 000/101.
- A rejected request is still handshaken but SHALL NOT be pushed; err_o SHALL pulse the cycle after acceptance and err_cnt_o SHALL increment, saturating at 255.
- Undefined: no request is rejected; imm_i SHALL be silently truncated per REQ-004..007; other I-ALU funct3 values SHALL use the REQ-004 format; err_o and err_cnt_o SHALL be tied to 0.

Verification
REQ-016 type=00, f3=000, rd=1, rs1=2, imm=0xFFFFFFFF -> next cycle instr_o=0xFFF10093, addr_o=0.
REQ-017 type=00, f3=101, rd=3, rs1=3, imm=5 -> instr_o=0x4051D193.
REQ-018 Store and branch encodings:
- type=10, f3=010, rs1=2, rs2=5, imm=8 -> instr_o=0x00512423.
- type=11, f3=000, rs1=1, rs2=2, imm=0xFFFFFFFE -> instr_o=0xFE208EE3.
REQ-019 Buffer full, with out_ready_i=0 and 5 requests offered:
- 4 are accepted, count_o=4, req_ready_o=0.
- Raising out_ready_i yields addr_o values 0,4,8,12 in order.
- Simultaneous push/pop at count 4 is impossible; at count 2, push+pop keeps count_o=2.
REQ-020 Range check, imm=2048, type=00, f3=000:
- With ENC_RANGE_CHECK_EN: err_o pulses once, err_cnt_o=1, count_o is unchanged, and the next valid push gets the unchanged address.
- Without it: the request is pushed with instr_o[31:20]=0x800.
- In both builds, rst_i low mid-stream -> count_o=0 and the next push has addr_o=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes I-ALU / load / store / branch requests into 32-bit
// instruction words and queues them, each tagged with a byte address, in a
// small FIFO for a downstream consumer.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   req_valid_i/ready_o   request handshake (ready only reflects free space)
//   type_i, funct3_i      instruction class and funct3 field
//   rd_i, rs1_i, rs2_i    register fields
//   imm_i                 signed 32-bit immediate
//   out_valid_o/ready_i   output handshake for the FIFO head
//   instr_o, addr_o       head instruction and its byte address (0 when empty)
//   count_o               FIFO occupancy
//   err_o, err_cnt_o      rejected-request pulse and saturating count
//
// Configuration macro: ENC_RANGE_CHECK_EN enables immediate/funct3 range
// checking with request rejection; without it immediates are truncated and
// err_o/err_cnt_o are tied to zero.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  type_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic [4:0]  count_o,
  output logic        err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  // Field placement for the four supported instruction classes.
  function automatic logic [31:0] encode(
    input logic [1:0]  typ,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] word;
    case (typ)
      2'b00: begin
        if (f3 == 3'b101) begin
          word = {7'b0100000, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          word = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      2'b01:   word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      2'b10:   word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      2'b11:   word = {imm[11], imm[9:4], rs2, rs1, f3, imm[3:0], imm[10], 7'b1100011};
      default: word = 32'd0;
    endcase
    return word;
  endfunction

`ifdef ENC_RANGE_CHECK_EN
  // True when the request cannot be encoded without losing information.
  function automatic logic out_of_range(
    input logic [1:0]  typ,
    input logic [2:0]  f3,
    input logic [31:0] imm
  );
    logic bad;
    // 12-bit signed range: bits [31:11] must all equal the sign bit.
    bad = (imm[31:11] != {21{imm[31]}});
    if (typ == 2'b00) begin
      if (f3 == 3'b101) begin
        bad = bad | (imm[31:5] != 27'd0);
      end else if (f3 != 3'b000) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end else begin
      bad = bad;
    end
    return bad;
  endfunction
`endif

  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [31:0]      addr_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]       count_q, count_d;
  logic [31:0]      addr_q, addr_d;
  logic             accept_s, reject_s, push_s, pop_s;
  logic [31:0]      enc_s;

`ifdef ENC_RANGE_CHECK_EN
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  assign reject_s  = out_of_range(type_i, funct3_i, imm_i);
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
`else
  // Upper immediate bits are deliberately discarded in this build.
  logic unused_imm_s;
  assign unused_imm_s = ^imm_i[31:12];
  assign reject_s     = 1'b0;
  assign err_o        = 1'b0;
  assign err_cnt_o    = 8'd0;
`endif

  assign req_ready_o = (count_q < DEPTH_C);
  assign out_valid_o = (count_q != 5'd0);
  assign count_o     = count_q;
  assign accept_s    = req_valid_i & req_ready_o;
  assign push_s      = accept_s & ~reject_s;
  assign pop_s       = out_valid_o & out_ready_i;
  assign enc_s       = encode(type_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i);

  // Next-state for pointers, occupancy, address counter and error tracking.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    addr_d   = push_s ? (addr_q + 32'd4) : addr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + 5'd1;
    end else if (pop_s && !push_s) begin
      count_d = count_q - 5'd1;
    end else begin
      count_d = count_q;
    end
`ifdef ENC_RANGE_CHECK_EN
    err_d = accept_s & reject_s;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
`endif
  end

  // State registers and FIFO storage; reset discards all buffered entries.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 5'd0;
      addr_q   <= 32'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= 32'd0;
        addr_mem_q[i]  <= 32'd0;
      end
`ifdef ENC_RANGE_CHECK_EN
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      if (push_s) begin
        instr_mem_q[wr_ptr_q] <= enc_s;
        addr_mem_q[wr_ptr_q]  <= addr_q;
      end
`ifdef ENC_RANGE_CHECK_EN
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  // Head-of-FIFO presentation, forced to zero while empty.
  always_comb begin
    if (out_valid_o) begin
      instr_o = instr_mem_q[rd_ptr_q];
      addr_o  = addr_mem_q[rd_ptr_q];
    end else begin
      instr_o = 32'd0;
      addr_o  = 32'd0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  type_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] instr_o, addr_o;
  logic [4:0]  count_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .type_i(type_i), .funct3_i(funct3_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .imm_i(imm_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .instr_o(instr_o), .addr_o(addr_o), .count_o(count_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state: FIFO of {instr, addr}, address counter, errors.
  logic [63:0] m_q[$];
  logic [31:0] m_addr;
  logic        m_err;
  int          m_errcnt;

  function automatic logic [31:0] ref_encode(int t, int f3, int rd, int rs1, int rs2, logic [31:0] imm);
    logic [31:0] r;
    logic [31:0] opc;
    case (t)
      0: opc = 32'h13;
      1: opc = 32'h03;
      2: opc = 32'h23;
      default: opc = 32'h63;
    endcase
    r = opc | (32'(f3) << 12) | (32'(rs1) << 15);
    if (t == 0) begin
      r = r | (32'(rd) << 7);
      if (f3 == 5) r = r | (32'h20 << 25) | ((imm & 32'h1F) << 20);
      else         r = r | ((imm & 32'hFFF) << 20);
    end else if (t == 1) begin
      r = r | (32'(rd) << 7) | ((imm & 32'hFFF) << 20);
    end else if (t == 2) begin
      r = r | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
    end else begin
      r = r | (32'(rs2) << 20) | (((imm >> 11) & 32'h1) << 31) | (((imm >> 10) & 32'h1) << 7)
            | (((imm >> 4) & 32'h3F) << 25) | ((imm & 32'hF) << 8);
    end
    return r;
  endfunction

  function automatic bit ref_reject(int t, int f3, logic [31:0] imm);
`ifdef ENC_RANGE_CHECK_EN
    int s;
    s = $signed(imm);
    if (s < -2048 || s > 2047) return 1'b1;
    if (t == 0 && f3 == 5 && (s < 0 || s > 31)) return 1'b1;
    if (t == 0 && f3 != 0 && f3 != 5) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: update the model from the current inputs, step, compare.
  task automatic cycle();
    bit acc, rej, pop;
    logic [63:0] head;
    if (!rst_i) begin
      m_q.delete();
      m_addr = 32'd0;
      m_err = 1'b0;
      m_errcnt = 0;
    end else begin
      acc = req_valid_i && (m_q.size() < DEPTH);
      rej = acc && ref_reject(type_i, funct3_i, imm_i);
      pop = (m_q.size() != 0) && out_ready_i;
      if (pop) void'(m_q.pop_front());
      if (acc && !rej) begin
        m_q.push_back({ref_encode(type_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i), m_addr});
        m_addr = m_addr + 32'd4;
      end
      m_err = rej;
      if (rej && m_errcnt < 255) m_errcnt++;
    end
    @(posedge clk_i);
    #1;
    head = (m_q.size() != 0) ? m_q[0] : 64'd0;
    chk("count", 32'(count_o), 32'(m_q.size()));
    chk("out_valid", 32'(out_valid_o), 32'(m_q.size() != 0));
    chk("req_ready", 32'(req_ready_o), 32'(m_q.size() < DEPTH));
    chk("instr", instr_o, head[63:32]);
    chk("addr", addr_o, head[31:0]);
    chk("err", 32'(err_o), 32'(m_err));
    chk("err_cnt", 32'(err_cnt_o), 32'(m_errcnt));
  endtask

  task automatic set_req(logic [1:0] t, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1,
                         logic [4:0] rs2, logic [31:0] imm);
    type_i = t; funct3_i = f3; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    req_valid_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b1;
    req_valid_i = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   rsel;

  initial begin
    rst_i = 1'b0; req_valid_i = 1'b0; out_ready_i = 1'b0;
    set_req(2'b00, 3'b000, 5'd0, 5'd0, 5'd0, 32'd0);

    vecs.push_back('{2'b00, 3'b000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093});
    vecs.push_back('{2'b00, 3'b101, 5'd3, 5'd3, 5'd0, 32'd5,        32'h4051D193});
    vecs.push_back('{2'b10, 3'b010, 5'd0, 5'd2, 5'd5, 32'd8,        32'h00512423});
    vecs.push_back('{2'b11, 3'b000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFE, 32'hFE208EE3});
    vecs.push_back('{2'b01, 3'b010, 5'd5, 5'd6, 5'd0, 32'hFFFFFFFC, 32'hFFC32283});
    vecs.push_back('{2'b10, 3'b000, 5'd0, 5'd1, 5'd31, 32'hFFFFFFFF, 32'hFFF08FA3});
    vecs.push_back('{2'b11, 3'b001, 5'd0, 5'd3, 5'd4, 32'd2047,     32'h7E419FE3});
`ifndef ENC_RANGE_CHECK_EN
    vecs.push_back('{2'b00, 3'b000, 5'd1, 5'd2, 5'd0, 32'd2048,     32'h80010093});
`endif

    // Reset state.
    do_reset();
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'd0);

    // Table-driven encodings: push one, check, drain.
    out_ready_i = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      set_req(vecs[i].t, vecs[i].f3, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      req_valid_i = 1'b1;
      cycle();
      chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'd1);
      if (i == 0) chk("vec0_addr", addr_o, 32'd0);
      req_valid_i = 1'b0;
      cycle();
    end

    // Fill: 5 offered with consumer stalled, then drain in order.
    do_reset();
    set_req(2'b00, 3'b000, 5'd7, 5'd8, 5'd0, 32'd1);
    out_ready_i = 1'b0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(req_ready_o), 32'd0);
    req_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_addr", k), addr_o, 32'(k * 4));
      cycle();
    end
    chk("drain_count", 32'(count_o), 32'd0);

    // Push and pop together at count 2.
    out_ready_i = 1'b0;
    req_valid_i = 1'b1;
    cycle();
    cycle();
    out_ready_i = 1'b1;
    cycle();
    chk("pushpop_count", 32'(count_o), 32'd2);
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Out-of-range immediate 2048.
    do_reset();
    out_ready_i = 1'b1;
    set_req(2'b00, 3'b000, 5'd1, 5'd2, 5'd0, 32'd2048);
    req_valid_i = 1'b1;
    cycle();
`ifdef ENC_RANGE_CHECK_EN
    chk("rc_err", 32'(err_o), 32'd1);
    chk("rc_errcnt", 32'(err_cnt_o), 32'd1);
    chk("rc_count", 32'(count_o), 32'd0);
    set_req(2'b00, 3'b000, 5'd1, 5'd2, 5'd0, 32'd5);
    cycle();
    chk("rc_err_pulse", 32'(err_o), 32'd0);
    chk("rc_next_addr", addr_o, 32'd0);
`else
    chk("trunc_imm", 32'(instr_o[31:20]), 32'h800);
    chk("trunc_addr", addr_o, 32'd0);
`endif
    req_valid_i = 1'b0;
    cycle();
    cycle();

    // Reset mid-stream with requests in flight.
    out_ready_i = 1'b0;
    req_valid_i = 1'b1;
    set_req(2'b01, 3'b000, 5'd4, 5'd5, 5'd0, 32'd16);
    for (int i = 0; i < 3; i++) cycle();
    rst_i = 1'b0;
    cycle();
    chk("midrst_count", 32'(count_o), 32'd0);
    chk("midrst_valid", 32'(out_valid_o), 32'd0);
    rst_i = 1'b1;
    cycle();
    chk("midrst_addr", addr_o, 32'd0);
    req_valid_i = 1'b0;
    out_ready_i = 1'b1;
    cycle();
    cycle();

`ifdef ENC_RANGE_CHECK_EN
    // Error counter saturation.
    do_reset();
    set_req(2'b01, 3'b000, 5'd1, 5'd1, 5'd0, 32'd4096);
    req_valid_i = 1'b1;
    for (int i = 0; i < 260; i++) cycle();
    chk("errcnt_sat", 32'(err_cnt_o), 32'd255);
    req_valid_i = 1'b0;
    cycle();
`endif

    // Randomized traffic checked against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rsel = int'($urandom_range(0, 3));
      case (rsel)
        0: imm_i = 32'($urandom_range(0, 31));
        1: imm_i = {{20{1'b0}}, 12'($urandom)} - ((($urandom & 1) != 0) ? 32'd2048 : 32'd0);
        2: imm_i = {{20{1'b1}}, 12'($urandom)};
        default: imm_i = $urandom;
      endcase
      type_i      = 2'($urandom);
      funct3_i    = ((($urandom & 1) != 0) && type_i == 2'b00) ? 3'(($urandom & 1) * 5) : 3'($urandom);
      rd_i        = 5'($urandom);
      rs1_i       = 5'($urandom);
      rs2_i       = 5'($urandom);
      req_valid_i = ($urandom_range(0, 3) != 0);
      out_ready_i = ($urandom_range(0, 2) != 0);
      rst_i       = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
